// File: rtl/wb_rr_master_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone master port between NREQ req/ack clients.
// Optional watchdog: define WB_RR_ARB_TIMEOUT_EN to terminate unanswered cycles with an error.
module wb_rr_master_arbiter #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned AW      = 1,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ-1:0]   we_i,
  input  logic [NREQ*AW-1:0] adr_i,
  input  logic [NREQ*32-1:0] dat_i,
  input  logic [NREQ*4-1:0] sel_i,
  output logic [NREQ-1:0]   ack_o,
  output logic [NREQ-1:0]   err_o,
  output logic [31:0]       dat_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [AW+1:2]     wb_adr_o,
  output logic [3:0]        wb_sel_o,
  output logic [31:0]       wb_dat_o,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
  input  logic              wb_rty_i,
  input  logic              wb_stall_i,
  input  logic [31:0]       wb_dat_i
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STROBE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   gnt_q, gnt_d;
  logic            cyc_d, stb_d, we_d;
  logic [AW-1:0]   adr_d;
  logic [3:0]      sel_d;
  logic [31:0]     wdat_d;
  logic [NREQ-1:0] ack_d, err_d;
  logic [31:0]     rdat_d;
  logic            found;
  int unsigned     idx;

`ifdef WB_RR_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    cyc_d   = wb_cyc_o;
    stb_d   = wb_stb_o;
    we_d    = wb_we_o;
    adr_d   = wb_adr_o;
    sel_d   = wb_sel_o;
    wdat_d  = wb_dat_o;
    ack_d   = '0;
    err_d   = '0;
    rdat_d  = dat_o;
    found   = 1'b0;
    idx     = 0;
`ifdef WB_RR_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        // Scan upward from the pointer, wrapping at NREQ; first hit wins.
        for (int unsigned i = 0; i < NREQ; i++) begin
          idx = int'(ptr_q) + i;
          if (idx >= NREQ) idx = idx - NREQ;
          if (!found && req_i[idx]) begin
            found  = 1'b1;
            gnt_d  = idx[PW-1:0];
            ptr_d  = (idx == NREQ - 1) ? '0 : PW'(idx + 1);
            we_d   = we_i[idx];
            adr_d  = adr_i[idx*AW +: AW];
            sel_d  = sel_i[idx*4 +: 4];
            wdat_d = dat_i[idx*32 +: 32];
          end
        end
        if (found) begin
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          state_d = S_STROBE;
`ifdef WB_RR_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      S_STROBE, S_WAIT: begin
        // Responses are honoured even while stalled: the slave drops stall with ack.
        if (wb_err_i || wb_rty_i) begin
          err_d[gnt_q] = 1'b1;
          cyc_d        = 1'b0;
          stb_d        = 1'b0;
          state_d      = S_DONE;
        end else if (wb_ack_i) begin
          ack_d[gnt_q] = 1'b1;
          if (!wb_we_o) rdat_d = wb_dat_i;
          cyc_d        = 1'b0;
          stb_d        = 1'b0;
          state_d      = S_DONE;
        end
`ifdef WB_RR_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d[gnt_q] = 1'b1;
          cyc_d        = 1'b0;
          stb_d        = 1'b0;
          state_d      = S_DONE;
        end
`endif
        else if (state_q == S_STROBE && !wb_stall_i) begin
          stb_d   = 1'b0;
          state_d = S_WAIT;
        end
`ifdef WB_RR_ARB_TIMEOUT_EN
        cnt_d = cnt_q + CW'(1);
`endif
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= '0;
      wb_sel_o <= '0;
      wb_dat_o <= '0;
      ack_o    <= '0;
      err_o    <= '0;
      dat_o    <= '0;
`ifdef WB_RR_ARB_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      wb_cyc_o <= cyc_d;
      wb_stb_o <= stb_d;
      wb_we_o  <= we_d;
      wb_adr_o <= adr_d;
      wb_sel_o <= sel_d;
      wb_dat_o <= wdat_d;
      ack_o    <= ack_d;
      err_o    <= err_d;
      dat_o    <= rdat_d;
`ifdef WB_RR_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_wb_rr_master_arbiter.sv
// Directed bench for wb_rr_master_arbiter (NREQ=2, AW=1, TIMEOUT=16); the bench drives the slave side.
module tb_wb_rr_master_arbiter;

  localparam int unsigned NREQ = 2;
  localparam int unsigned AW   = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req, we;
  logic [NREQ*AW-1:0] adr;
  logic [NREQ*32-1:0] dat;
  logic [NREQ*4-1:0] sel;
  logic [NREQ-1:0]   ack, err;
  logic [31:0]       rdat;
  logic              cyc, stb, wwe;
  logic [AW+1:2]     wadr;
  logic [3:0]        wsel;
  logic [31:0]       wdat;
  logic              s_ack, s_err, s_rty, s_stall;
  logic [31:0]       s_dat;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  wb_rr_master_arbiter #(.NREQ(NREQ), .AW(AW), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_i(req), .we_i(we), .adr_i(adr), .dat_i(dat), .sel_i(sel),
    .ack_o(ack), .err_o(err), .dat_o(rdat),
    .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(wwe), .wb_adr_o(wadr),
    .wb_sel_o(wsel), .wb_dat_o(wdat),
    .wb_ack_i(s_ack), .wb_err_i(s_err), .wb_rty_i(s_rty),
    .wb_stall_i(s_stall), .wb_dat_i(s_dat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned n;
    rst_n = 1'b0; req = '0; we = '0; adr = '0; dat = '0; sel = '0;
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_stall = 1'b0; s_dat = '0;
    tick(); tick();
    check("rst_cyc", 32'(cyc), 0);
    check("rst_stb", 32'(stb), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_err", 32'(err), 0);
    check("rst_dat", rdat, 0);
    check("rst_adr", 32'(wadr), 0);
    rst_n = 1'b1;

    // Single write from client 0, one stall cycle then ack in WAIT
    req = 2'b01; we = 2'b01; adr = 2'b01; dat = {32'h0, 32'hDEADBEEF}; sel = 8'h0F;
    s_stall = 1'b1;
    tick();
    check("wr_cyc", 32'(cyc), 1);
    check("wr_stb", 32'(stb), 1);
    check("wr_we", 32'(wwe), 1);
    check("wr_adr", 32'(wadr), 1);
    check("wr_wdat", wdat, 32'hDEADBEEF);
    check("wr_sel", 32'(wsel), 32'hF);
    tick();
    check("wr_stall_stb", 32'(stb), 1);
    s_stall = 1'b0;
    tick();
    check("wr_wait_stb", 32'(stb), 0);
    check("wr_wait_cyc", 32'(cyc), 1);
    check("wr_noack_early", 32'(ack), 0);
    s_ack = 1'b1; s_dat = 32'h5A5A5A5A;
    tick();
    check("wr_ack", 32'(ack), 32'b01);
    check("wr_done_cyc", 32'(cyc), 0);
    check("wr_rdat_kept", rdat, 0);
    s_ack = 1'b0; req = '0;
    tick();
    check("wr_ack_1cyc", 32'(ack), 0);

    // Fairness from a fresh reset: both request, grants must alternate 0,1,0,1
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    we = '0; adr = 2'b10; req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("fair_grant_adr", 32'(wadr), 32'(k % 2));
      req = 2'b11;
      s_ack = 1'b1;
      tick();
      check("fair_ack", 32'(ack), (k % 2 == 0) ? 32'b01 : 32'b10);
      s_ack = 1'b0;
      req = (k % 2 == 0) ? 2'b10 : 2'b01;
      tick();
    end
    req = '0;
    tick();

    // Read from client 1 at adr 0
    req = 2'b10; we = 2'b00; adr = 2'b01; s_dat = 32'h12345678;
    tick();
    check("rd_adr", 32'(wadr), 0);
    check("rd_we", 32'(wwe), 0);
    s_ack = 1'b1;
    tick();
    check("rd_ack", 32'(ack), 32'b10);
    check("rd_dat", rdat, 32'h12345678);
    s_ack = 1'b0; req = '0;
    tick();

    // Write must leave dat_o alone
    req = 2'b01; we = 2'b01; s_dat = 32'hAAAA5555;
    tick();
    s_ack = 1'b1;
    tick();
    check("wr2_ack", 32'(ack), 32'b01);
    check("wr2_rdat_kept", rdat, 32'h12345678);
    s_ack = 1'b0; req = '0;
    tick();

    // err together with ack: error wins, no data latch
    req = 2'b01; we = 2'b00; s_dat = 32'hCAFEF00D;
    tick();
    s_ack = 1'b1; s_err = 1'b1;
    tick();
    check("err_err", 32'(err), 32'b01);
    check("err_noack", 32'(ack), 0);
    check("err_rdat_kept", rdat, 32'h12345678);
    s_ack = 1'b0; s_err = 1'b0; req = '0;
    tick();

    // rty alone while stalled still completes with error
    req = 2'b01;
    tick();
    s_rty = 1'b1; s_stall = 1'b1;
    tick();
    check("rty_err", 32'(err), 32'b01);
    check("rty_noack", 32'(ack), 0);
    check("rty_cyc", 32'(cyc), 0);
    s_rty = 1'b0; s_stall = 1'b0; req = '0;
    tick();
    check("rty_err_1cyc", 32'(err), 0);

    // Unanswered cycle
    req = 2'b01;
    tick();
`ifdef WB_RR_ARB_TIMEOUT_EN
    n = 0;
    while (cyc && n < 100) begin
      n++;
      tick();
    end
    check("tmo_cycles", n, 16);
    check("tmo_err", 32'(err), 32'b01);
    req = '0;
    tick();
    req = 2'b01;
    tick();
    tick();
`else
    n = 0;
    for (int c = 0; c < 1000; c++) begin
      if (cyc) n++;
      tick();
    end
    check("notmo_cycles", n, 1000);
    check("notmo_cyc", 32'(cyc), 1);
    check("notmo_err", 32'(err), 0);
`endif

    // Reset while in WAIT with client 0 in flight (pointer would be 1)
    check("mid_in_wait", 32'({cyc, stb}), 32'b10);
    rst_n = 1'b0; req = 2'b11; adr = 2'b10;
    tick();
    check("mid_rst_cyc", 32'(cyc), 0);
    check("mid_rst_ack", 32'(ack), 0);
    check("mid_rst_err", 32'(err), 0);
    rst_n = 1'b1;
    tick();
    check("mid_idle_ack", 32'(ack | err), 0);
    tick();
    check("mid_regrant_cyc", 32'(cyc), 1);
    check("mid_regrant_adr", 32'(wadr), 0);
    s_ack = 1'b1;
    tick();
    check("mid_regrant_ack", 32'(ack), 32'b01);
    s_ack = 1'b0; req = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
